// File: rtl/clock_set_ctrl.sv
// HH:MM time-setting controller: debounced mode/inc keys edit shadow BCD
// hours then minutes, then hand the result to the counters via valid/ready.
module clock_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode_n,
  input  logic       btn_inc_n,
  input  logic [3:0] cur_hour_tens,
  input  logic [3:0] cur_hour_ones,
  input  logic [3:0] cur_min_tens,
  input  logic [3:0] cur_min_ones,
  input  logic       load_ready,
  output logic [3:0] set_hour_tens,
  output logic [3:0] set_hour_ones,
  output logic [3:0] set_min_tens,
  output logic [3:0] set_min_ones,
  output logic       load_valid,
  output logic       hold,
  output logic [1:0] field_sel
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN, S_HOUR, S_MIN, S_COMMIT
  } state_t;

  // bit 0 = mode key, bit 1 = inc key
  logic [1:0]         r_s1;
  logic [1:0]         r_s2;
  logic [1:0]         r_db;
  logic [1:0][DW-1:0] r_cnt;
  logic [1:0]         w_fall;
  logic [RW-1:0]      r_rep;
  logic               w_rep;
  logic               r_mode_ev;
  logic               r_inc_ev;

  state_t r_state;
  state_t w_next;

  logic [3:0] r_ht, r_ho, r_mt, r_mo;
  logic       w_hr_ok, w_mn_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1  <= 2'b11;
      r_s2  <= 2'b11;
      r_db  <= 2'b11;
      r_cnt <= '0;
    end else begin
      r_s1 <= {btn_inc_n, btn_mode_n};
      r_s2 <= r_s1;
      // Returning to the accepted level is the only way the level can change
      // while counting, so that doubles as the restart-on-change rule.
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DB_LAST) begin
          r_cnt[i] <= '0;
          r_db[i]  <= r_s2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_fall = '0;
    for (int i = 0; i < 2; i++) begin
      w_fall[i] = r_db[i] && !r_s2[i]
               && (r_cnt[i] == DB_LAST);
    end
  end

  assign w_rep = !r_db[1] && (r_rep == RP_LAST);

  always_ff @(posedge clk) begin
    if (rst || r_db[1] || w_rep) begin
      r_rep <= '0;
    end else begin
      r_rep <= r_rep + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode_ev <= 1'b0;
      r_inc_ev  <= 1'b0;
    end else begin
      r_mode_ev <= w_fall[0];
      r_inc_ev  <= w_fall[1] | w_rep;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_RUN:    if (r_mode_ev) w_next = S_HOUR;
      S_HOUR:   if (r_mode_ev) w_next = S_MIN;
      S_MIN:    if (r_mode_ev) w_next = S_COMMIT;
      S_COMMIT: if (load_ready) w_next = S_RUN;
      default:  w_next = S_RUN;
    endcase
  end

  always_comb begin
    hold       = (r_state != S_RUN);
    load_valid = (r_state == S_COMMIT);
    field_sel  = 2'b00;
    if (r_state == S_HOUR) field_sel = 2'b01;
    if (r_state == S_MIN)  field_sel = 2'b10;
  end

  always_comb begin
    w_hr_ok = ((cur_hour_tens < 4'd2) && (cur_hour_ones <= 4'd9))
           || ((cur_hour_tens == 4'd2) && (cur_hour_ones <= 4'd3));
    w_mn_ok = (cur_min_tens <= 4'd5) && (cur_min_ones <= 4'd9);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ht <= '0;
      r_ho <= '0;
      r_mt <= '0;
      r_mo <= '0;
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (r_mode_ev) begin
            r_ht <= w_hr_ok ? cur_hour_tens : 4'd0;
            r_ho <= w_hr_ok ? cur_hour_ones : 4'd0;
            r_mt <= w_mn_ok ? cur_min_tens  : 4'd0;
            r_mo <= w_mn_ok ? cur_min_ones  : 4'd0;
          end
        end
        S_HOUR: begin
          if (r_inc_ev && !r_mode_ev) begin
            if (r_ht == 4'd2 && r_ho == 4'd3) begin
              r_ht <= 4'd0;
              r_ho <= 4'd0;
            end else if (r_ho == 4'd9) begin
              r_ho <= 4'd0;
              r_ht <= r_ht + 4'd1;
            end else begin
              r_ho <= r_ho + 4'd1;
            end
          end
        end
        S_MIN: begin
          if (r_inc_ev && !r_mode_ev) begin
            if (r_mo == 4'd9) begin
              r_mo <= 4'd0;
              r_mt <= (r_mt == 4'd5) ? 4'd0 : r_mt + 4'd1;
            end else begin
              r_mo <= r_mo + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign set_hour_tens = r_ht;
  assign set_hour_ones = r_ho;
  assign set_min_tens  = r_mt;
  assign set_min_ones  = r_mo;

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-setting controller for the HH:MM wall clock. Takes the two raw board push-buttons (mode, increment), debounces them, and edits hours then minutes in shadow BCD registers. It then writes the edited time into the running time counters through a valid/ready load handshake. It sits between the board keys and the hour/minute/second counter chain, and drives the hold and field-select signals used by the counters and the seven-segment display path.

## Interface
- DEBOUNCE_CYCLES, 500000: clk cycles a synchronized button level must be stable before it is accepted (10 ms at 50 MHz).
- REPEAT_CYCLES, 25000000: auto-repeat period for a held increment button (0.5 s at 50 MHz).
- clk  in  1  system clock (50 MHz).
- rst  in  1  reset, synchronous, active-high.
- btn_mode_n  in  1  raw mode key, active-low, asynchronous to clk.
- btn_inc_n  in  1  raw increment key, active-low, asynchronous to clk.
- cur_hour_tens, cur_hour_ones, cur_min_tens, cur_min_ones  in  4 each  live BCD time from the counters.
- load_ready  in  1  counters accept the load this cycle.
- set_hour_tens, set_hour_ones, set_min_tens, set_min_ones  out  4 each  shadow BCD time being edited or loaded.
- load_valid  out  1  shadow time is presented for loading.
- hold  out  1  counters must freeze while high.
- field_sel  out  2  field being edited: 00 none, 01 hours, 10 minutes (display blinks this field).

## Operation
- Each button passes through a 2-flop synchronizer, then a debouncer.
- The debouncer counter restarts on any change of the synchronized level.
- The debounced level updates when the synchronized level has held for DEBOUNCE_CYCLES.
- A press event is a 1-cycle pulse on the debounced high-to-low transition.
- Increment auto-repeat: while debounced inc stays low, one extra inc event is generated every REPEAT_CYCLES after the press event. The repeat counter clears on release.
- FSM states and transitions:
  - RUN: on a mode event, capture cur_* into the shadow registers and go to EDIT_HOUR.
  - EDIT_HOUR: an inc event increments hours; a mode event goes to EDIT_MIN.
  - EDIT_MIN: an inc event increments minutes; a mode event goes to COMMIT.
  - COMMIT: when load_valid and load_ready are both high, go to RUN. Button events are ignored in COMMIT.
- Hour increment in BCD:
  - 23 wraps to 00.
  - ones == 9 sets ones to 0 and increments tens.
  - Otherwise ones increments.
- Minute increment in BCD:
  - ones == 9 sets ones to 0 and increments tens.
  - 59 wraps to 00.
- Capture sanitizing:
  - If captured hours are not a valid BCD value 00..23, the shadow hours become 00.
  - If captured minutes are not a valid BCD value 00..59, the shadow minutes become 00.
- Simultaneous mode and inc events in the same cycle: mode wins and the inc is dropped.
- Outputs by state:
  - hold is 1 in EDIT_HOUR, EDIT_MIN and COMMIT; 0 in RUN.
  - field_sel is 01 in EDIT_HOUR, 10 in EDIT_MIN, 00 otherwise.
- The counters clear seconds to 0 on an accepted load; this block carries no seconds field.

## Timing
- Reset values: FSM state RUN, all set_* 0, load_valid 0, hold 0, field_sel 00. Debounced levels reset to 1 (released). Debounce and repeat counters reset to 0.
- Button latency: a raw edge produces an event 2 sync cycles + DEBOUNCE_CYCLES + 1 cycle later.
- Glitches shorter than DEBOUNCE_CYCLES produce no event.
- Events are registered; the state change and the shadow update appear in the cycle after the event pulse.
- cur_* are sampled in the event cycle.
- load_valid is registered high from the first COMMIT cycle.
- Once load_valid is high, set_* are stable until the handshake completes.
- load_valid drops in the cycle after valid&ready.
- hold drops together with load_valid, so the counters resume on the loaded value.
- load_ready high while load_valid is low has no effect.
- rst mid-edit or mid-COMMIT abandons the shadow value: no load, next cycle is RUN with all outputs at reset values.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16.
1. Press mode with cur time 14:37 -> field_sel=01, hold=1, set_*=1,4,3,7. Inc ×10 -> set hours 00, 01 ... reaches 00 after 23.
2. Edit minutes from 58: inc ×2 -> 59 then 00, hours unchanged. Mode -> load_valid=1. Hold load_ready=0 for 5 cycles -> set_* stable. load_ready=1 -> next cycle load_valid=0, hold=0, field_sel=00.
3. Bounce btn_inc_n with 3-cycle pulses -> no increment. Clean press held for 60 cycles -> 1 press increment plus 3 auto-repeat increments.
4. Mode and inc events in the same cycle in EDIT_HOUR -> state EDIT_MIN, hours unchanged.
5. Capture of invalid cur time 2A:7F -> shadow 00:00. rst asserted during EDIT_MIN -> next cycle RUN, load_valid=0, hold=0, set_*=0.
